// File: rtl/pulse_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package : pulse_sched_pkg
// Shared FSM state encoding and width helper for the pulse scheduler.
// Rev     : 1.0
// ============================================================================
package pulse_sched_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] PULSE = 2'd1;
    localparam logic [STATE_W-1:0] GAP   = 2'd2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface : pulse_scheduler_if
// Trigger, pulse-length and status signals between requesters and scheduler.
// Rev       : 1.0
// ============================================================================
interface pulse_scheduler_if #(
    parameter int NumChannels      = 4,
    parameter int PulseLengthWidth = 8,
    parameter int HoldoffWidth     = 4,
    parameter int ChanIdWidth      = 2
);
    logic                                    enable;
    logic [NumChannels-1:0]                  trigger;
    logic [NumChannels*PulseLengthWidth-1:0] pulselength;
    logic [HoldoffWidth-1:0]                 holdoff;
    logic                                    q;
    logic [ChanIdWidth-1:0]                  active_chan;
    logic                                    busy;
    logic [NumChannels-1:0]                  pending;
    logic [NumChannels-1:0]                  dropped;

    modport master (
        output enable, trigger, pulselength, holdoff,
        input  q, active_chan, busy, pending, dropped
    );

    modport slave (
        input  enable, trigger, pulselength, holdoff,
        output q, active_chan, busy, pending, dropped
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Combinational round-robin pick: first request above ptr, with wrap-around.
// Rev    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NumChannels = 4,
    parameter int ChanIdWidth = 2
) (
    input  wire  [NumChannels-1:0] req,
    input  wire  [ChanIdWidth-1:0] ptr,
    output logic [ChanIdWidth-1:0] grant,
    output logic                   grant_valid
);

    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = 1; k <= NumChannels; k++) begin
            idx = (int'(ptr) + k) % NumChannels;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant       = ChanIdWidth'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module : pulse_scheduler
// Queues per-channel trigger edges and drives one shared timed pulse line,
// served round-robin. Define PULSE_SCHED_HOLDOFF_EN to add holdoff dead time.
// Rev    : 1.0
// ============================================================================
module pulse_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int NumChannels      = 4,
    parameter int PulseLengthWidth = 8,
    parameter int HoldoffWidth     = 4,
    parameter int ChanIdWidth      = 2
) (
    input  wire              clock,
    input  wire              reset_n,
    pulse_scheduler_if.slave bus
);

    generate
        if (ChanIdWidth != clog2(NumChannels)) begin : g_bad_chan_id_width
            $error("ChanIdWidth must equal clog2(NumChannels)");
        end
    endgenerate

    logic [STATE_W-1:0]          r_state;
    logic [STATE_W-1:0]          w_state_next;
    logic [NumChannels-1:0]      r_trig_d;
    logic [NumChannels-1:0]      r_pending;
    logic [NumChannels-1:0]      r_dropped;
    logic [NumChannels-1:0]      w_edge;
    logic [NumChannels-1:0]      w_capture;
    logic [NumChannels-1:0]      w_clear;
    logic [NumChannels-1:0]      w_pending_next;
    logic [NumChannels-1:0]      w_dropped_next;
    logic [ChanIdWidth-1:0]      r_ptr;
    logic [ChanIdWidth-1:0]      r_active;
    logic [ChanIdWidth-1:0]      w_grant;
    logic                        w_grant_valid;
    logic                        w_take;
    logic                        w_start;
    logic [PulseLengthWidth-1:0] w_len;
    logic [PulseLengthWidth-1:0] r_count;
    logic [PulseLengthWidth-1:0] w_count_next;
    logic                        r_q;
    logic                        w_q_next;
    logic                        w_pulse_last;

`ifdef PULSE_SCHED_HOLDOFF_EN
    logic [HoldoffWidth-1:0]     r_gap;
    logic [HoldoffWidth-1:0]     w_gap_next;
`else
    logic                        unused_holdoff;
    assign unused_holdoff = ^bus.holdoff;
`endif

    rr_arbiter #(
        .NumChannels (NumChannels),
        .ChanIdWidth (ChanIdWidth)
    ) u_arb (
        .req         (r_pending),
        .ptr         (r_ptr),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    assign w_edge       = bus.trigger & ~r_trig_d;
    assign w_capture    = bus.enable ? w_edge : '0;
    assign w_take       = (r_state == IDLE) && bus.enable && w_grant_valid;
    assign w_len        = bus.pulselength[int'(w_grant)*PulseLengthWidth +: PulseLengthWidth];
    assign w_start      = w_take && (w_len != '0);
    assign w_pulse_last = (r_count == PulseLengthWidth'(1));
    assign w_clear      = w_take ? (NumChannels'(1) << w_grant) : '0;

    // A fresh edge on the channel being granted re-queues it rather than dropping.
    assign w_pending_next = (r_pending & ~w_clear) | w_capture;
    assign w_dropped_next = w_capture & r_pending & ~w_clear;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_trig_d  <= '0;
            r_pending <= '0;
            r_dropped <= '0;
            r_ptr     <= ChanIdWidth'(NumChannels - 1);
            r_active  <= '0;
            r_count   <= '0;
            r_q       <= 1'b0;
`ifdef PULSE_SCHED_HOLDOFF_EN
            r_gap     <= '0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_trig_d  <= bus.trigger;
            r_pending <= w_pending_next;
            r_dropped <= w_dropped_next;
            r_count   <= w_count_next;
            r_q       <= w_q_next;
`ifdef PULSE_SCHED_HOLDOFF_EN
            r_gap     <= w_gap_next;
`endif
            if (w_take) begin
                r_ptr    <= w_grant;
                r_active <= w_grant;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next = PULSE;
                end
            end
            PULSE: begin
                if (w_pulse_last) begin
`ifdef PULSE_SCHED_HOLDOFF_EN
                    w_state_next = (bus.holdoff != '0) ? GAP : IDLE;
`else
                    w_state_next = IDLE;
`endif
                end
            end
`ifdef PULSE_SCHED_HOLDOFF_EN
            GAP: begin
                if (r_gap == HoldoffWidth'(1)) begin
                    w_state_next = IDLE;
                end
            end
`endif
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_q_next     = r_q;
        w_count_next = r_count;
`ifdef PULSE_SCHED_HOLDOFF_EN
        w_gap_next   = r_gap;
`endif
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_q_next     = 1'b1;
                    w_count_next = w_len;
                end
            end
            PULSE: begin
                if (w_pulse_last) begin
                    w_q_next = 1'b0;
`ifdef PULSE_SCHED_HOLDOFF_EN
                    w_gap_next = bus.holdoff;
`endif
                end else begin
                    w_count_next = r_count - PulseLengthWidth'(1);
                end
            end
`ifdef PULSE_SCHED_HOLDOFF_EN
            GAP: begin
                w_q_next   = 1'b0;
                w_gap_next = r_gap - HoldoffWidth'(1);
            end
`endif
            default: w_q_next = 1'b0;
        endcase
    end

    assign bus.q           = r_q;
    assign bus.active_chan = r_active;
    assign bus.busy        = (r_state != IDLE);
    assign bus.pending     = r_pending;
    assign bus.dropped     = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_pulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_pulse_scheduler
// Directed bench with a timeline-based reference model of the scheduler.
// Rev    : 1.0
// ============================================================================
module tb_pulse_scheduler;

    localparam int N   = 4;
    localparam int PLW = 8;
    localparam int HW  = 4;
    localparam int CW  = 2;
`ifdef PULSE_SCHED_HOLDOFF_EN
    localparam bit HOLDOFF_ON = 1'b1;
`else
    localparam bit HOLDOFF_ON = 1'b0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    pulse_scheduler_if #(
        .NumChannels(N), .PulseLengthWidth(PLW), .HoldoffWidth(HW), .ChanIdWidth(CW)
    ) bus ();

    pulse_scheduler #(
        .NumChannels(N), .PulseLengthWidth(PLW), .HoldoffWidth(HW), .ChanIdWidth(CW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each grant books a time window for the pulse and dead time.
    int             cyc;
    int             free_at;
    int             p_start, p_end, b_end;
    int             m_g, m_len, m_h;
    bit             m_found;
    logic [N-1:0]   m_pend, m_drop, m_trig_d, m_edges, m_gmask;
    int             m_ptr, m_act;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0; free_at = 0; p_start = 1; p_end = 0; b_end = 0;
            m_pend = '0; m_drop = '0; m_trig_d = '0; m_ptr = N - 1; m_act = 0;
        end else begin
            cyc++;
            m_edges  = bus.trigger & ~m_trig_d;
            m_trig_d = bus.trigger;
            m_gmask  = '0;
            if (bus.enable && cyc >= free_at && m_pend != '0) begin
                m_found = 1'b0;
                m_g     = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!m_found && m_pend[(m_ptr + k) % N]) begin
                        m_found = 1'b1;
                        m_g     = (m_ptr + k) % N;
                    end
                end
                m_gmask[m_g] = 1'b1;
                m_ptr = m_g;
                m_act = m_g;
                m_len = int'(bus.pulselength[m_g*PLW +: PLW]);
                m_h   = HOLDOFF_ON ? int'(bus.holdoff) : 0;
                if (m_len == 0) begin
                    free_at = cyc + 1;
                end else begin
                    p_start = cyc;
                    p_end   = cyc + m_len - 1;
                    b_end   = cyc + m_len - 1 + m_h;
                    free_at = cyc + m_len + 1 + m_h;
                end
            end
            m_drop = bus.enable ? (m_edges & m_pend & ~m_gmask) : '0;
            m_pend = (m_pend & ~m_gmask) | (bus.enable ? m_edges : '0);
        end
    end

    always @(negedge clock) begin
        check("q",           int'(bus.q),           int'(cyc >= p_start && cyc <= p_end));
        check("busy",        int'(bus.busy),        int'(cyc >= p_start && cyc <= b_end));
        check("pending",     int'(bus.pending),     int'(m_pend));
        check("dropped",     int'(bus.dropped),     int'(m_drop));
        check("active_chan", int'(bus.active_chan), m_act);
    end

    // Pulse log: channel at each rise, high lengths, low gaps between pulses.
    int rise_chan[$];
    int hi_lens[$];
    int gaps[$];
    int hi_len, lo_len;
    int drop_cnt[N];
    bit seen, q_prev;

    always @(negedge clock) begin
        if (bus.q && !q_prev) begin
            rise_chan.push_back(int'(bus.active_chan));
            if (seen) gaps.push_back(lo_len);
            hi_len = 1;
        end else if (bus.q) begin
            hi_len++;
        end else if (q_prev) begin
            hi_lens.push_back(hi_len);
            seen   = 1'b1;
            lo_len = 1;
        end else begin
            lo_len++;
        end
        q_prev = bus.q;
        for (int i = 0; i < N; i++) if (bus.dropped[i]) drop_cnt[i]++;
    end

    task automatic clear_log();
        rise_chan.delete();
        hi_lens.delete();
        gaps.delete();
        seen = 1'b0;
        for (int i = 0; i < N; i++) drop_cnt[i] = 0;
    endtask

    task automatic check_seq(input string name, input int got[$],
                             input int e0, input int e1 = -1, input int e2 = -1);
        int exp[3];
        int n;
        exp = '{e0, e1, e2};
        n = (e0 >= 0 ? 1 : 0) + (e1 >= 0 ? 1 : 0) + (e2 >= 0 ? 1 : 0);
        check({name, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d]", name, i), (i < got.size()) ? got[i] : -1, exp[i]);
        end
    endtask

    task automatic wait_cyc(input int k);
        repeat (k) @(posedge clock);
        #2;
    endtask

    task automatic pulse_trig(input logic [N-1:0] mask);
        bus.trigger = mask;
        wait_cyc(1);
        bus.trigger = '0;
    endtask

    task automatic set_len(input int ch, input int len);
        bus.pulselength[ch*PLW +: PLW] = PLW'(len);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wait_cyc(2);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.enable      = 1'b1;
        bus.trigger     = '0;
        bus.pulselength = '0;
        bus.holdoff     = '0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_q",       int'(bus.q), 0);
        check("rst_busy",    int'(bus.busy), 0);
        check("rst_pending", int'(bus.pending), 0);
        check("rst_active",  int'(bus.active_chan), 0);
        wait_cyc(2);
        reset_n = 1'b1;

        // Single request, ch1 L=5
        set_len(1, 5);
        clear_log();
        pulse_trig(4'b0010);
        @(negedge clock);
        check("t1_pending", int'(bus.pending), 2);
        check("t1_q_before_grant", int'(bus.q), 0);
        wait_cyc(10);
        check_seq("t1_rise", rise_chan, 1);
        check_seq("t1_len", hi_lens, 5);

        // Simultaneous ch0/2/3, L=3, from a fresh pointer
        do_reset();
        set_len(0, 3); set_len(2, 3); set_len(3, 3);
        clear_log();
        pulse_trig(4'b1101);
        wait_cyc(20);
        check_seq("t2_rise", rise_chan, 0, 2, 3);
        check_seq("t2_len", hi_lens, 3, 3, 3);
        check_seq("t2_gap", gaps, 1, 1);
        clear_log();
        pulse_trig(4'b1001);
        wait_cyc(15);
        check_seq("t2b_rise", rise_chan, 0, 3);

        // Re-trigger during a long pulse: one re-queue, one drop
        set_len(2, 10);
        clear_log();
        pulse_trig(4'b0100);
        wait_cyc(2);
        pulse_trig(4'b0100);
        wait_cyc(2);
        pulse_trig(4'b0100);
        wait_cyc(30);
        check_seq("t3_rise", rise_chan, 2, 2);
        check_seq("t3_len", hi_lens, 10, 10);
        check_seq("t3_gap", gaps, 1);
        check("t3_drops", drop_cnt[2], 1);

        // Zero-length ch1 consumes its turn, then ch2 pulses
        set_len(1, 0); set_len(2, 4);
        clear_log();
        pulse_trig(4'b0110);
        @(negedge clock);
        check("t4_pend_both", int'(bus.pending), 6);
        @(negedge clock);
        check("t4_pend_after_zero", int'(bus.pending), 4);
        check("t4_q_zero", int'(bus.q), 0);
        check("t4_active_zero", int'(bus.active_chan), 1);
        @(negedge clock);
        check("t4_q_ch2", int'(bus.q), 1);
        check("t4_active_ch2", int'(bus.active_chan), 2);
        wait_cyc(10);
        check_seq("t4_rise", rise_chan, 2);
        check_seq("t4_len", hi_lens, 4);

        // Disable with two requests queued, then re-enable
        set_len(0, 6); set_len(1, 3); set_len(3, 2);
        clear_log();
        pulse_trig(4'b0001);
        wait_cyc(1);
        pulse_trig(4'b1010);
        wait_cyc(1);
        bus.enable = 1'b0;
        wait_cyc(2);
        pulse_trig(4'b0100);
        wait_cyc(10);
        check("t5_pend_held", int'(bus.pending), 10);
        check("t5_no_drop", drop_cnt[2], 0);
        check_seq("t5_rise_dis", rise_chan, 0);
        bus.enable = 1'b1;
        wait_cyc(20);
        check_seq("t5_rise", rise_chan, 0, 1, 3);
        check_seq("t5_len", hi_lens, 6, 3, 2);

        // Asynchronous reset in the middle of a pulse
        clear_log();
        pulse_trig(4'b0001);
        wait_cyc(2);
        pulse_trig(4'b0010);
        check("t6_q_mid", int'(bus.q), 1);
        check("t6_pend_mid", int'(bus.pending), 2);
        reset_n = 1'b0;
        #1;
        check("t6_q_async", int'(bus.q), 0);
        check("t6_pend_async", int'(bus.pending), 0);
        check("t6_busy_async", int'(bus.busy), 0);
        check("t6_active_async", int'(bus.active_chan), 0);
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(2);

        // Back-to-back pulses with and without holdoff
        bus.holdoff = 4'd4;
        set_len(0, 2); set_len(1, 2);
        clear_log();
        pulse_trig(4'b0011);
        wait_cyc(20);
        check_seq("t7_rise", rise_chan, 0, 1);
        check_seq("t7_gap", gaps, HOLDOFF_ON ? 5 : 1);
        bus.holdoff = 4'd0;
        clear_log();
        pulse_trig(4'b0011);
        wait_cyc(15);
        check_seq("t7b_rise", rise_chan, 0, 1);
        check_seq("t7b_gap", gaps, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
